// File: rtl/s100_uart_pkg.sv
// Shared types and constants for the S-100 console UART receive path.
package s100_uart_pkg;

    localparam int UART_DEFAULT_DIVIDER = 208;
    localparam int UART_DATA_W          = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Circular-buffer receive FIFO with show-ahead head. A pop in the same cycle
// as a push on a full buffer frees the slot the push then fills.
module rx_fifo
    import s100_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] push_data,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] head,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    logic                   do_push;
    logic                   do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// 8N1 serial receiver feeding the ACIA: single holding register by default,
// or a FIFO_DEPTH-entry FIFO when UART_RX_FIFO_EN is defined.
module uart_rx_engine
    import s100_uart_pkg::*;
#(
    parameter int DIVIDER    = UART_DEFAULT_DIVIDER,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    input  logic                   rd,
    output logic [UART_DATA_W-1:0] data_out,
    output logic                   valid,
    output logic                   overrun,
    output logic                   frame_err
);

    localparam int CW = $clog2(DIVIDER);

    rx_state_e              state;
    logic                   rx_meta;
    logic                   rxs;
    logic                   rxs_d;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shift_reg;
    logic                   falling;
    logic                   sample;
    logic                   push;
    logic                   full;
    logic                   pop_ok;
    logic                   overrun_ev;
    logic                   ferr_ev;

    // Synchroniser idles high so reset never fabricates a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign falling = rxs_d & ~rxs;
    assign sample  = (cnt == '0);
    assign push    = (state == STOP) && sample;
    assign ferr_ev = push & ~rxs;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (falling) begin
                        cnt   <= CW'(DIVIDER/2 - 1);
                        state <= START;
                    end
                end
                START: begin
                    if (sample) begin
                        if (!rxs) begin
                            cnt     <= CW'(DIVIDER - 1);
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift_reg <= {rxs, shift_reg[UART_DATA_W-1:1]};
                        cnt       <= CW'(DIVIDER - 1);
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (sample) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    logic fifo_empty;

    rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift_reg),
        .pop       (rd),
        .head      (data_out),
        .empty     (fifo_empty),
        .full      (full)
    );

    assign valid = ~fifo_empty;
`else
    logic [UART_DATA_W-1:0] hold_reg;
    logic                   hold_full;

    // Depth-1 storage: a pop frees the register for a same-cycle push.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else begin
            if (push && (!hold_full || rd)) begin
                hold_reg  <= shift_reg;
                hold_full <= 1'b1;
            end else if (rd) begin
                hold_full <= 1'b0;
            end
        end
    end

    assign data_out = hold_reg;
    assign valid    = hold_full;
    assign full     = hold_full;
`endif

    assign pop_ok     = rd & valid;
    assign overrun_ev = push & full & ~rd;

    // Set events are applied after the pop clear so they win a tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (pop_ok) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            if (overrun_ev) begin
                overrun <= 1'b1;
            end
            if (ferr_ev) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine at DIVIDER=16 with a byte scoreboard;
// covers both the holding-register and UART_RX_FIFO_EN builds.
module tb_uart_rx_engine;
    import s100_uart_pkg::*;

    localparam int DIV = 16;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rd;
    logic [7:0] data_out;
    logic       valid;
    logic       overrun;
    logic       frame_err;

    logic [7:0] exp_q[$];
    logic       exp_ovr;
    logic       exp_ferr;
    int         n_checks;
    int         n_pass;

    uart_rx_engine #(.DIVIDER(DIV), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd        (rd),
        .data_out  (data_out),
        .valid     (valid),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Frame timing is counted from the edge before the start bit is driven.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                             input bit lat_check, input bit rd_at_push);
        logic [9:0] frame;
        bit popped;
        frame  = {stop_bit, b, 1'b0};
        popped = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            for (int k = 1; k <= DIV; k++) begin
                @(posedge clk); #1;
                if (i == 9 && k == 10) begin
                    if (lat_check) check("latency_154_low", {7'd0, valid}, 8'd0);
                    if (rd_at_push && exp_q.size() != 0) begin
                        check("head_at_push", data_out, exp_q[0]);
                        rd     = 1'b1;
                        popped = 1'b1;
                    end
                end
                if (i == 9 && k == 11) begin
                    rd = 1'b0;
                    if (lat_check) check("latency_155_high", {7'd0, valid}, 8'd1);
                end
            end
        end
        if (popped) begin
            void'(exp_q.pop_front());
            exp_ovr  = 1'b0;
            exp_ferr = 1'b0;
        end
        if (exp_q.size() < CAP) exp_q.push_back(b);
        else                    exp_ovr = 1'b1;
        if (!stop_bit) exp_ferr = 1'b1;
    endtask

    task automatic rd_pulse(input string tag);
        bit had;
        had = (exp_q.size() != 0);
        if (had) check(tag, data_out, exp_q[0]);
        rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        if (had) begin
            void'(exp_q.pop_front());
            exp_ovr  = 1'b0;
            exp_ferr = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid"}, {7'd0, valid}, {7'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) check({tag, "_data"}, data_out, exp_q[0]);
        check({tag, "_overrun"}, {7'd0, overrun}, {7'd0, exp_ovr});
        check({tag, "_frame_err"}, {7'd0, frame_err}, {7'd0, exp_ferr});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, {7'd0, valid}, 8'd0);
        check({tag, "_data"}, data_out, 8'h00);
        check({tag, "_overrun"}, {7'd0, overrun}, 8'd0);
        check({tag, "_frame_err"}, {7'd0, frame_err}, 8'd0);
    endtask

    initial begin
        logic [7:0] fill_val;
        n_checks = 0;
        n_pass   = 0;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        reset    = 1'b1;
        rx       = 1'b1;
        rd       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        check("reset_fsm", 8'(dut.state), 8'(IDLE));
        reset = 1'b0;
        idle(5);

        // Good frame with exact latency.
        send_byte(8'hA5, 1'b1, 1'b1, 1'b0);
        check_state("a5");
        rd_pulse("a5_pop");
        check_state("a5_after_pop");
        idle(5);

        // Short low glitch must be rejected at the start-bit sample.
        rx = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        idle(30);
        check_state("glitch");
        check("glitch_fsm", 8'(dut.state), 8'(IDLE));

        // Low stop bit: byte kept, frame_err set, cleared by read.
        send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        idle(5);
        check_state("ferr");
        rd_pulse("ferr_pop");
        check_state("ferr_after_pop");

        // Overflow storage by one byte.
        for (int i = 0; i <= CAP; i++) begin
`ifdef UART_RX_FIFO_EN
            fill_val = 8'(i + 1);
`else
            fill_val = 8'(17 * (i + 1));
`endif
            send_byte(fill_val, 1'b1, 1'b0, 1'b0);
        end
        idle(3);
        check_state("ovr");
        while (exp_q.size() != 0) begin
            rd_pulse("ovr_pop");
            check_state("ovr_drain");
        end

        // Full storage, pop on the push cycle of a bad-stop frame.
        for (int i = 0; i < CAP; i++) begin
            send_byte(8'hC0 + 8'(i), 1'b1, 1'b0, 1'b0);
        end
        check_state("full");
        send_byte(8'h99, 1'b0, 1'b0, 1'b1);
        idle(3);
        check_state("pop_push");
        while (exp_q.size() != 0) begin
            rd_pulse("pp_pop");
        end
        check_state("pp_drained");

        // rd on empty storage does nothing.
        rd_pulse("empty_rd");
        rd_pulse("empty_rd2");
        check_state("empty_rd");

        // Reset in the middle of a data bit discards everything.
        send_byte(8'h55, 1'b1, 1'b0, 1'b0);
        check_state("pre_reset");
        rx = 1'b0;
        repeat (DIV + 40) begin
            @(posedge clk); #1;
        end
        check("mid_data_fsm", 8'(dut.state), 8'(DATA));
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_values("mid_reset");
        rx = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        idle(5);
        check("post_reset_fsm", 8'(dut.state), 8'(IDLE));
        send_byte(8'h7E, 1'b1, 1'b0, 1'b0);
        idle(3);
        check_state("7e");
        rd_pulse("7e_pop");
        check_state("7e_done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
